// File: rtl/dsm_sample_feeder_pkg.sv
// -----------------------------------------------------------------------------
// dsm_feeder_pkg
// Shared definitions for the delta-sigma sample feeder:
//   feeder_state_e : playback FSM states (IDLE, FILL, PLAY)
//   mid_value()    : offset-binary silence code 2^(width-1) for a given width
// -----------------------------------------------------------------------------
package dsm_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PLAY = 2'd2
    } feeder_state_e;

    // Midscale of an unsigned offset-binary code is the MSB alone.
    function automatic logic [31:0] mid_value(input int unsigned width);
        mid_value = 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/dsm_sample_feeder_if.sv
// -----------------------------------------------------------------------------
// dsm_sample_feeder_if
// Valid/ready source bus carrying one stereo PCM pair per transfer.
//   s_valid        : source has a pair on s_left/s_right
//   s_ready        : sink accepts the pair this cycle
//   s_left/s_right : offset-binary PCM samples, DSM_WIDTH bits each
// Modports: master = sample source, slave = feeder.
// -----------------------------------------------------------------------------
interface dsm_sample_feeder_if #(
    parameter int DSM_WIDTH = 12
) ();

    logic                 s_valid;
    logic                 s_ready;
    logic [DSM_WIDTH-1:0] s_left;
    logic [DSM_WIDTH-1:0] s_right;

    modport master (
        output s_valid,
        output s_left,
        output s_right,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_left,
        input  s_right,
        output s_ready
    );

endinterface

// File: rtl/dsm_sample_feeder_fifo.sv
// -----------------------------------------------------------------------------
// stereo_sync_fifo
// Single-clock first-word-fall-through FIFO holding packed {left, right} pairs.
//   clk, aclr : clock, synchronous active-high reset
//   flush     : empties the FIFO at the next edge (wins over push/pop)
//   push      : write wr_data (ignored when full)
//   pop       : discard the head entry (ignored when empty)
//   rd_data   : current head entry, valid whenever level != 0
//   level     : occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module stereo_sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     aclr,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (level != FULL_LEVEL);
    assign do_pop  = pop  && (level != '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (aclr || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the pointers and level define which
    // entries are meaningful, so clearing the data itself buys nothing.
    always_ff @(posedge clk) begin
        if (do_push && !aclr && !flush) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/dsm_sample_feeder.sv
// -----------------------------------------------------------------------------
// dsm_sample_feeder
// Buffers stereo PCM pairs from a valid/ready source and presents one pair per
// sample period to a stereo delta-sigma modulator.
//   clk, aclr    : clock, synchronous active-high reset
//   enable       : playback enable; low = idle, FIFO flushed, outputs midscale
//   src          : source bus (slave side): s_valid, s_ready, s_left, s_right
//   left_pcm     : registered left sample to the modulator
//   right_pcm    : registered right sample to the modulator
//   sample_tick  : one-cycle pulse per CLK_DIV clocks while enabled
//   fifo_level   : current FIFO occupancy
//   underrun     : sticky flag, set when a tick finds the FIFO empty in PLAY
//   underrun_clr : clears underrun (a coincident set wins)
// Playback: IDLE -> FILL (wait for START_LEVEL pairs) -> PLAY (pop one pair per
// tick); an empty FIFO at a tick drops back to FILL and holds the last sample.
// -----------------------------------------------------------------------------
module dsm_sample_feeder
    import dsm_feeder_pkg::*;
#(
    parameter int DSM_WIDTH   = 12,
    parameter int CLK_DIV     = 1024,
    parameter int FIFO_DEPTH  = 4,
    parameter int START_LEVEL = 2
) (
    input  logic                          clk,
    input  logic                          aclr,
    input  logic                          enable,
    dsm_sample_feeder_if.slave            src,
    output logic [DSM_WIDTH-1:0]          left_pcm,
    output logic [DSM_WIDTH-1:0]          right_pcm,
    output logic                          sample_tick,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    input  logic                          underrun_clr
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [DSM_WIDTH-1:0] MID        = DSM_WIDTH'(mid_value(DSM_WIDTH));
    localparam logic [CW-1:0]        CNT_LAST   = CW'(CLK_DIV - 1);
    localparam logic [LW-1:0]        FULL_LEVEL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0]        START_LVL  = LW'(START_LEVEL);

    feeder_state_e              state_q;
    feeder_state_e              state_d;
    logic [CW-1:0]              tick_cnt;
    logic                       ready;
    logic                       push;
    logic                       pop;
    logic                       flush;
    logic                       underrun_set;
    logic [2*DSM_WIDTH-1:0]     head;

    // ---------------------------------------------------------------- tick --
    always_ff @(posedge clk) begin
        if (aclr || !enable)          tick_cnt <= '0;
        else if (tick_cnt == CNT_LAST) tick_cnt <= '0;
        else                          tick_cnt <= tick_cnt + 1'b1;
    end

    assign sample_tick = enable && (tick_cnt == CNT_LAST);

    // ------------------------------------------------------------ handshake --
    // IDLE never accepts: anything pushed there would be flushed anyway.
    assign ready       = enable && (state_q != IDLE) && (fifo_level < FULL_LEVEL);
    assign src.s_ready = ready;
    assign push        = src.s_valid && ready;
    assign flush       = !enable || (state_q == IDLE);

    stereo_sync_fifo #(
        .WIDTH (2 * DSM_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .aclr    (aclr),
        .flush   (flush),
        .push    (push),
        .wr_data ({src.s_left, src.s_right}),
        .pop     (pop),
        .rd_data (head),
        .level   (fifo_level)
    );

    // ----------------------------------------------------------------- FSM --
    always_ff @(posedge clk) begin
        if (aclr) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        underrun_set = 1'b0;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = FILL;
                FILL: if (fifo_level >= START_LVL) state_d = PLAY;
                PLAY: begin
                    if (sample_tick) begin
                        if (fifo_level != '0) begin
                            pop = 1'b1;
                        end else begin
                            underrun_set = 1'b1;
                            state_d      = FILL;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------- outputs --
    // The FIFO head is captured at the edge that pops it, so the new sample
    // appears the cycle after the tick.
    always_ff @(posedge clk) begin
        if (aclr || !enable) begin
            left_pcm  <= MID;
            right_pcm <= MID;
        end else if (pop) begin
            left_pcm  <= head[2*DSM_WIDTH-1:DSM_WIDTH];
            right_pcm <= head[DSM_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (aclr)              underrun <= 1'b0;
        else if (underrun_set) underrun <= 1'b1;
        else if (underrun_clr) underrun <= 1'b0;
    end

endmodule

// File: tb/tb_dsm_sample_feeder.sv
// -----------------------------------------------------------------------------
// tb_dsm_sample_feeder
// Self-checking bench for dsm_sample_feeder (W=12, CLK_DIV=8, DEPTH=4, START=2).
// A behavioural model (pair queue, cycle count since enable, playing flag)
// predicts the outputs; directed scenarios also compare against constants.
// -----------------------------------------------------------------------------
module tb_dsm_sample_feeder;

    localparam int W     = 12;
    localparam int DIV   = 8;
    localparam int DEPTH = 4;
    localparam int START = 2;
    localparam logic [W-1:0] MID = 12'h800;

    logic         clk = 1'b0;
    logic         aclr;
    logic         enable;
    logic         underrun_clr;
    logic [W-1:0] left_pcm;
    logic [W-1:0] right_pcm;
    logic         sample_tick;
    logic [2:0]   fifo_level;
    logic         underrun;

    dsm_sample_feeder_if #(.DSM_WIDTH(W)) bus ();

    dsm_sample_feeder #(
        .DSM_WIDTH   (W),
        .CLK_DIV     (DIV),
        .FIFO_DEPTH  (DEPTH),
        .START_LEVEL (START)
    ) dut (
        .clk          (clk),
        .aclr         (aclr),
        .enable       (enable),
        .src          (bus),
        .left_pcm     (left_pcm),
        .right_pcm    (right_pcm),
        .sample_tick  (sample_tick),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ------------------------------------------------------ reference model --
    logic [23:0] m_q[$];
    int          m_cycles  = 0;
    bit          m_armed   = 0;
    bit          m_playing = 0;
    bit          m_und     = 0;
    logic [W-1:0] m_l = MID;
    logic [W-1:0] m_r = MID;

    function automatic bit exp_tick();
        return (enable === 1'b1) && (m_cycles % DIV == DIV - 1);
    endfunction

    function automatic bit exp_ready();
        return (enable === 1'b1) && m_armed && (m_q.size() < DEPTH);
    endfunction

    // Apply this cycle's inputs to the model, then move to posedge + 1.
    task automatic advance();
        bit          tk    = exp_tick();
        bit          rd    = exp_ready();
        int          lvl   = m_q.size();
        bit          under = (enable === 1'b1) && m_playing && tk && (lvl == 0);
        logic [23:0] pair;
        if (aclr === 1'b1 || enable !== 1'b1) begin
            m_q.delete();
            m_cycles  = 0;
            m_armed   = 0;
            m_playing = 0;
            m_l       = MID;
            m_r       = MID;
        end else begin
            if (m_playing && tk) begin
                if (lvl > 0) begin
                    pair = m_q.pop_front();
                    m_l  = pair[23:12];
                    m_r  = pair[11:0];
                end else begin
                    m_playing = 0;
                end
            end else if (!m_playing && m_armed && lvl >= START) begin
                m_playing = 1;
            end
            if (bus.s_valid === 1'b1 && rd) m_q.push_back({bus.s_left, bus.s_right});
            m_armed  = 1;
            m_cycles = m_cycles + 1;
        end
        if (aclr === 1'b1)              m_und = 0;
        else if (under)                 m_und = 1;
        else if (underrun_clr === 1'b1) m_und = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        @(negedge clk);
        advance();
    endtask

    // Records each distinct output pair as it appears.
    bit          rec_on = 0;
    logic [23:0] rec_prev;
    logic [23:0] seen_q[$];

    always @(negedge clk) begin
        if (rec_on && {left_pcm, right_pcm} !== rec_prev) begin
            seen_q.push_back({left_pcm, right_pcm});
            rec_prev = {left_pcm, right_pcm};
        end
    end

    task automatic start_recording();
        seen_q.delete();
        rec_prev = {left_pcm, right_pcm};
        rec_on   = 1;
    endtask

    // ---------------------------------------------------------------- tests --
    task automatic test_reset();
        aclr = 1; enable = 1; underrun_clr = 0;
        bus.s_valid = 1; bus.s_left = 12'h123; bus.s_right = 12'h456;
        repeat (2) cycle();
        aclr = 0;
        @(negedge clk);
        n_vec++;
        if (left_pcm !== MID || right_pcm !== MID) begin
            n_err++; $display("FAIL reset_pcm: got %h/%h want %h/%h", left_pcm, right_pcm, MID, MID);
        end
        n_vec++;
        if (fifo_level !== 3'd0 || underrun !== 1'b0 || sample_tick !== 1'b0) begin
            n_err++; $display("FAIL reset_state: level=%0d und=%b tick=%b want 0/0/0", fifo_level, underrun, sample_tick);
        end
        n_vec++;
        if (bus.s_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_ready: got %b want 0", bus.s_ready);
        end
        advance();
        enable = 0; bus.s_valid = 0;
        cycle();
    endtask

    task automatic test_fill_idle();
        int ticks = 0;
        enable = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_vec++;
            if (sample_tick !== exp_tick()) begin
                n_err++; $display("FAIL fill_tick: cycle %0d got %b want %b", i, sample_tick, exp_tick());
            end
            n_vec++;
            if (left_pcm !== MID || right_pcm !== MID || underrun !== 1'b0 || fifo_level !== 3'd0) begin
                n_err++; $display("FAIL fill_state: cycle %0d pcm %h/%h und %b lvl %0d", i, left_pcm, right_pcm, underrun, fifo_level);
            end
            if (sample_tick === 1'b1) ticks++;
            advance();
        end
        n_vec++;
        if (ticks != 5) begin
            n_err++; $display("FAIL fill_tick_count: got %0d want 5", ticks);
        end
    endtask

    task automatic test_play_order();
        logic [23:0] pairs [3] = '{24'h100F00, 24'h200E00, 24'h300D00};
        bit acc;
        start_recording();
        for (int p = 0; p < 3; p++) begin
            bus.s_valid = 1; bus.s_left = pairs[p][23:12]; bus.s_right = pairs[p][11:0];
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                n_vec++;
                if (bus.s_ready !== exp_ready()) begin
                    n_err++; $display("FAIL play_ready: got %b want %b", bus.s_ready, exp_ready());
                end
                acc = exp_ready();
                advance();
                if (acc) break;
            end
        end
        bus.s_valid = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            n_vec++;
            if (left_pcm !== m_l || right_pcm !== m_r || fifo_level !== 3'(m_q.size())) begin
                n_err++; $display("FAIL play_step: cycle %0d got %h/%h lvl %0d want %h/%h lvl %0d",
                                  i, left_pcm, right_pcm, fifo_level, m_l, m_r, m_q.size());
            end
            advance();
        end
        rec_on = 0;
        n_vec++;
        if (seen_q.size() != 3) begin
            n_err++; $display("FAIL play_count: got %0d output changes want 3", seen_q.size());
        end else begin
            for (int p = 0; p < 3; p++) begin
                n_vec++;
                if (seen_q[p] !== pairs[p]) begin
                    n_err++; $display("FAIL play_pair%0d: got %h want %h", p, seen_q[p], pairs[p]);
                end
            end
        end
        n_vec++;
        if (underrun !== 1'b1 || left_pcm !== 12'h300 || right_pcm !== 12'hD00) begin
            n_err++; $display("FAIL first_underrun: und %b pcm %h/%h want 1 300/d00", underrun, left_pcm, right_pcm);
        end
    endtask

    task automatic test_underrun_clr();
        bit fire, hit = 0, acc;
        int pushed = 0;
        underrun_clr = 1;
        cycle();
        underrun_clr = 0;
        @(negedge clk);
        n_vec++;
        if (underrun !== 1'b0) begin
            n_err++; $display("FAIL und_clear: got %b want 0", underrun);
        end
        advance();
        for (int i = 0; i < 100; i++) begin
            bus.s_valid  = (pushed < 2);
            bus.s_left   = 12'($urandom);
            bus.s_right  = 12'($urandom);
            underrun_clr = m_playing && exp_tick() && (m_q.size() == 0);
            @(negedge clk);
            n_vec++;
            if (underrun !== m_und) begin
                n_err++; $display("FAIL und_track: got %b want %b", underrun, m_und);
            end
            acc  = (bus.s_valid === 1'b1) && exp_ready();
            fire = underrun_clr;
            advance();
            if (acc) pushed++;
            if (fire) begin
                hit = 1;
                break;
            end
        end
        underrun_clr = 0; bus.s_valid = 0;
        @(negedge clk);
        n_vec++;
        if (!hit || underrun !== 1'b1) begin
            n_err++; $display("FAIL und_set_wins: hit %b und %b want 1/1", hit, underrun);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        logic [23:0] src [6];
        int idx = 0, max_lvl = 0;
        bit acc;
        for (int i = 0; i < 6; i++) src[i] = 24'($urandom);
        enable = 0;
        cycle();
        enable = 1;
        start_recording();
        for (int i = 0; i < 120; i++) begin
            bus.s_valid = (idx < 6);
            if (idx < 6) begin
                bus.s_left  = src[idx][23:12];
                bus.s_right = src[idx][11:0];
            end
            @(negedge clk);
            n_vec++;
            if (bus.s_ready !== exp_ready() || left_pcm !== m_l || right_pcm !== m_r) begin
                n_err++; $display("FAIL b2b_cycle%0d: rdy %b pcm %h/%h want %b %h/%h",
                                  i, bus.s_ready, left_pcm, right_pcm, exp_ready(), m_l, m_r);
            end
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
            if (fifo_level === 3'd4) begin
                n_vec++;
                if (bus.s_ready !== 1'b0) begin
                    n_err++; $display("FAIL b2b_full_ready: got %b want 0", bus.s_ready);
                end
            end
            acc = (bus.s_valid === 1'b1) && exp_ready();
            advance();
            if (acc) idx++;
        end
        rec_on = 0;
        bus.s_valid = 0;
        n_vec++;
        if (idx != 6 || max_lvl != 4 || seen_q.size() != 6) begin
            n_err++; $display("FAIL b2b_totals: sent %0d maxlvl %0d played %0d want 6/4/6", idx, max_lvl, seen_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_vec++;
                if (seen_q[i] !== src[i]) begin
                    n_err++; $display("FAIL b2b_pair%0d: got %h want %h", i, seen_q[i], src[i]);
                end
            end
        end
    endtask

    task automatic buffer_three();
        bit ok = 0;
        for (int i = 0; i < 80; i++) begin
            if (m_l != MID && m_q.size() == 3) begin
                ok = 1;
                break;
            end
            bus.s_valid = (m_q.size() < 3);
            bus.s_left  = 12'($urandom);
            bus.s_right = 12'($urandom);
            cycle();
        end
        n_vec++;
        if (!ok || fifo_level !== 3'd3) begin
            n_err++; $display("FAIL buffer_three: lvl %0d want 3 within budget", fifo_level);
        end
    endtask

    task automatic test_disable_and_reset();
        int first = -1;
        buffer_three();
        bus.s_valid = 1; enable = 0;
        @(negedge clk);
        n_vec++;
        if (bus.s_ready !== 1'b0) begin
            n_err++; $display("FAIL dis_ready_now: got %b want 0", bus.s_ready);
        end
        advance();
        enable = 1;
        @(negedge clk);
        n_vec++;
        if (left_pcm !== MID || right_pcm !== MID || fifo_level !== 3'd0) begin
            n_err++; $display("FAIL dis_flush: pcm %h/%h lvl %0d want 800/800 0", left_pcm, right_pcm, fifo_level);
        end
        n_vec++;
        if (bus.s_ready !== 1'b0 || sample_tick !== 1'b0) begin
            n_err++; $display("FAIL dis_ready_tick: rdy %b tick %b want 0/0", bus.s_ready, sample_tick);
        end
        bus.s_valid = 0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            if (sample_tick === 1'b1 && first < 0) first = k;
            advance();
            if (first >= 0) break;
        end
        n_vec++;
        if (first != DIV - 1) begin
            n_err++; $display("FAIL dis_tick_restart: first tick at %0d want %0d", first, DIV - 1);
        end
        buffer_three();
        aclr = 1; bus.s_valid = 1;
        cycle();
        aclr = 0;
        @(negedge clk);
        n_vec++;
        if (left_pcm !== MID || right_pcm !== MID || fifo_level !== 3'd0) begin
            n_err++; $display("FAIL rst_flush: pcm %h/%h lvl %0d want 800/800 0", left_pcm, right_pcm, fifo_level);
        end
        n_vec++;
        if (bus.s_ready !== 1'b0 || sample_tick !== 1'b0 || underrun !== 1'b0) begin
            n_err++; $display("FAIL rst_ready_tick: rdy %b tick %b und %b want 0/0/0", bus.s_ready, sample_tick, underrun);
        end
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            aclr         = ($urandom_range(0, 199) == 0);
            enable       = ($urandom_range(0, 99) != 0);
            underrun_clr = ($urandom_range(0, 19) == 0);
            bus.s_valid  = ($urandom_range(0, 9) < 4);
            bus.s_left   = 12'($urandom);
            bus.s_right  = 12'($urandom);
            @(negedge clk);
            n_vec++;
            if (left_pcm !== m_l || right_pcm !== m_r || fifo_level !== 3'(m_q.size()) ||
                sample_tick !== exp_tick() || bus.s_ready !== exp_ready() || underrun !== m_und) begin
                n_err++;
                $display("FAIL rand_cycle%0d: pcm %h/%h lvl %0d tick %b rdy %b und %b want %h/%h %0d %b %b %b",
                         i, left_pcm, right_pcm, fifo_level, sample_tick, bus.s_ready, underrun,
                         m_l, m_r, m_q.size(), exp_tick(), exp_ready(), m_und);
            end
            advance();
        end
        aclr = 0; underrun_clr = 0; bus.s_valid = 0;
    endtask

    initial begin
        test_reset();
        test_fill_idle();
        test_play_order();
        test_underrun_clr();
        test_back_to_back();
        test_disable_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dsm_sample_feeder.md
DSM_SAMPLE_FEEDER -- requirements
Module: dsm_sample_feeder

Interface
REQ-001: Parameter DSM_WIDTH, default 12, PCM sample width (offset binary, unsigned).
REQ-002: Parameter CLK_DIV, default 1024, clk cycles per sample period (>=4).
REQ-003: Parameter FIFO_DEPTH, default 4, stereo sample pairs buffered (power of 2, >=2).
REQ-004: Parameter START_LEVEL, default 2, FIFO level required to start or resume playback (1..FIFO_DEPTH).
REQ-005: clk  in  1  single clock; all logic on its rising edge.
REQ-006: aclr  in  1  reset, synchronous, active-high.
REQ-007: enable  in  1  playback enable; 0 = idle, flush, output midscale.
REQ-008: s_valid  in  1  source sample pair valid.
REQ-009: s_ready  out  1  feeder accepts pair this cycle.
REQ-010: s_left / s_right  in  DSM_WIDTH each  source PCM pair.
REQ-011: left_pcm / right_pcm  out  DSM_WIDTH each  registered samples driving the stereo modulator.
REQ-012: sample_tick  out  1  one-cycle pulse per sample period.
REQ-013: fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-014: underrun  out  1  sticky underrun flag.
REQ-015: underrun_clr  in  1  clears underrun.

Function
REQ-016: MID = 2^(DSM_WIDTH-1); the silence value for both channels.
REQ-017: Tick counter counts 0..CLK_DIV-1 and wraps while enable=1; held at 0 while enable=0; sample_tick=1 exactly when counter==CLK_DIV-1 and enable=1.
REQ-018: Push occurs when s_valid & s_ready; s_ready = enable & (fifo_level < FIFO_DEPTH), combinational from registered level.
REQ-019: Simultaneous push and pop leave fifo_level unchanged; FIFO order is strict first-in first-out, left/right always kept paired.
REQ-020: FSM states IDLE, FILL, PLAY.
REQ-021: IDLE: outputs MID, FIFO flushed (level 0); enable=1 -> FILL next cycle.
REQ-022: FILL: outputs hold their current value; no pops; when fifo_level >= START_LEVEL -> PLAY next cycle.
REQ-023: PLAY: on sample_tick with level>0, pop head; left_pcm/right_pcm take the popped pair at the following edge (1-cycle latency from tick).
REQ-024: PLAY: on sample_tick with level==0, outputs hold last sample, underrun set to 1, state -> FILL.
REQ-025: enable=0 in any state -> IDLE next cycle; outputs MID, FIFO flushed, tick counter 0; an in-flight push that cycle is discarded (s_ready already 0).
REQ-026: underrun_clr clears the flag next cycle; if set and clear coincide, set wins.
REQ-027: A source holding s_valid=1 with s_ready=0 must not lose or duplicate data when s_ready returns to 1.

Reset
REQ-028: aclr=1 at a rising edge: state IDLE, FIFO pointers and level 0, tick counter 0, left_pcm=right_pcm=MID, sample_tick=0, underrun=0, s_ready=0 the following cycle.
REQ-029: Reset mid-playback discards all buffered samples; no pop or push completes in the reset cycle.

Structure
REQ-030: Package dsm_feeder_pkg holds the FSM state enumeration (IDLE, FILL, PLAY) and the MID computation as a width-parameterised constant function.
REQ-031: One sub-module, stereo_sync_fifo (2*DSM_WIDTH wide, FIFO_DEPTH deep, push/pop/flush, level output); FSM, tick counter and output registers stay in dsm_sample_feeder.

Verification (DSM_WIDTH=12, CLK_DIV=8, FIFO_DEPTH=4, START_LEVEL=2)
REQ-032: Reset then enable=1, no pushes -> outputs 0x800/0x800, sample_tick every 8 cycles, state FILL, underrun stays 0.
REQ-033: Push pairs (0x100,0xF00),(0x200,0xE00),(0x300,0xD00) -> PLAY after level reaches 2; outputs step to each pair one cycle after successive ticks, in order.
REQ-034: Source s_valid held high continuously with 6 pairs -> s_ready drops at level 4, exactly 6 pairs played in order, none lost or duplicated.
REQ-035: Let FIFO drain during PLAY -> at first empty tick underrun=1, outputs hold last pair, state FILL; underrun_clr on same cycle as a second underrun -> flag remains 1.
REQ-036: enable=0 (and separately aclr=1) with 3 pairs buffered -> next cycle outputs 0x800, fifo_level 0, tick counter 0, s_ready 0.
